// File: rtl/gcd_job_issuer.sv
// Job issuer for a start/done GCD engine: buffers operand pairs in a FIFO, issues them one at a
// time, resolves zero operands locally, aborts hung jobs on timeout and returns results valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a queued job; pops the FIFO head into the job regs
// ISSUE | one-cycle gcd_start pulse, timeout timer loaded
// WAIT  | operands held on gcd_a/gcd_b until gcd_done or timer terminal count
// RESP  | result presented on out_*, held until out_ready
module gcd_job_issuer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_res,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] head_a, head_b;

    logic [WIDTH-1:0] job_a, job_b, res_gcd;
    logic             res_err;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] job_a_nx, job_b_nx, res_gcd_nx;
    logic             res_err_nx;
    logic [TW-1:0]    timer_nx;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_a = mem_a[rd_ptr[AW-1:0]];
    assign head_b = mem_b[rd_ptr[AW-1:0]];

    // Gated by rst_n so in_ready reads 0 while reset is held.
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= in_a;
            mem_b[wr_ptr[AW-1:0]] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            job_a   <= '0;
            job_b   <= '0;
            res_gcd <= '0;
            res_err <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_nx;
            job_a   <= job_a_nx;
            job_b   <= job_b_nx;
            res_gcd <= res_gcd_nx;
            res_err <= res_err_nx;
            timer   <= timer_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        job_a_nx   = job_a;
        job_b_nx   = job_b;
        res_gcd_nx = res_gcd;
        res_err_nx = res_err;
        timer_nx   = timer;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    job_a_nx = head_a;
                    job_b_nx = head_b;
                    // gcd(x,0)=x needs no engine; gcd(0,0) is undefined and flagged.
                    if ((head_a == '0) || (head_b == '0)) begin
                        res_gcd_nx = head_a | head_b;
                        res_err_nx = (head_a == '0) && (head_b == '0);
                        state_nx   = S_RESP;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_nx = TW'(TIMEOUT);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (gcd_done) begin
                    res_gcd_nx = gcd_res;
                    res_err_nx = 1'b0;
                    state_nx   = S_RESP;
                end else if (timer == '0) begin
                    res_gcd_nx = '0;
                    res_err_nx = 1'b1;
                    state_nx   = S_RESP;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            S_RESP: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign gcd_start = (state == S_ISSUE);
    assign gcd_a     = job_a;
    assign gcd_b     = job_b;
    assign out_valid = (state == S_RESP);
    assign out_a     = job_a;
    assign out_b     = job_b;
    assign out_gcd   = res_gcd;
    assign out_err   = res_err;
    assign busy      = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_gcd_job_issuer.sv
// Bench for gcd_job_issuer: directed scenarios plus a randomized run against a
// queue-based reference model and a behavioural GCD engine.
module tb_gcd_job_issuer;

    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 1023;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [WIDTH-1:0] in_a = '0, in_b = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [WIDTH-1:0] out_a, out_b, out_gcd;
    logic             out_err;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a, gcd_b;
    logic             gcd_done = 1'b0;
    logic [WIDTH-1:0] gcd_res = '0;
    logic             busy;

    always #5 clk = ~clk;

    gcd_job_issuer #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_gcd(out_gcd), .out_err(out_err),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_res(gcd_res), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic       err;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   got_total = 0;
    int   start_cnt = 0;
    bit   eng_hang = 0, rand_delay = 0, rand_ready = 0;
    int   eng_delay = 6;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input bit hang);
        res_t r;
        r.a = a;
        r.b = b;
        if (a == 0 || b == 0) begin
            r.g   = a | b;
            r.err = (a == 0 && b == 0);
        end else if (hang) begin
            r.g   = 0;
            r.err = 1'b1;
        end else begin
            r.g   = ref_gcd(a, b);
            r.err = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: collects handshaken results and checks valid/data hold under back-pressure.
    logic pv = 0, pr = 0, ps = 0;
    res_t pres = '0;
    always @(negedge clk) begin
        res_t cur;
        cur = {out_a, out_b, out_gcd, out_err};
        if (!rst_n) begin
            pv = 0;
            ps = 0;
        end else begin
            if (gcd_start) start_cnt++;
            if (ps) chk("start_single_cycle", 32'(gcd_start), 0);
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(cur), 32'(pres));
            end
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                got_total++;
            end
            pv   = out_valid;
            pr   = out_ready;
            ps   = gcd_start;
            pres = cur;
        end
    end

    // Behavioural engine: answers gcd_done after a delay unless told to hang.
    bit         eng_busy = 0;
    int         eng_cnt = 0;
    logic [7:0] ea = 0, eb = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_busy = 0;
            gcd_done = 1'b0;
            gcd_res  = '0;
        end else if (gcd_done) begin
            gcd_done = 1'b0;
            gcd_res  = '0;
            eng_busy = 0;
        end else if (gcd_start) begin
            eng_busy = 1;
            ea       = gcd_a;
            eb       = gcd_b;
            eng_cnt  = rand_delay ? int'($urandom_range(1, 8)) : eng_delay;
        end else if (eng_busy && !eng_hang) begin
            if (eng_cnt <= 1) begin
                chk("operands_held", 32'({gcd_a, gcd_b}), 32'({ea, eb}));
                gcd_done = 1'b1;
                gcd_res  = ref_gcd(ea, eb);
            end else begin
                eng_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_job(input logic [7:0] a, input logic [7:0] b, input int budget);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(acc), 1);
        if (acc) exp_q.push_back(model(a, b, eng_hang));
    endtask

    task automatic drain(input string tag, input int budget);
        bit   ok;
        res_t e, g;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= exp_q.size() && !busy) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({tag, "_drain"}, 32'(ok), 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            chk(tag, 32'(g), 32'(e));
        end
        chk({tag, "_extra"}, 32'(got_q.size()), 0);
    endtask

    initial begin
        int   s0, base, cnt;
        bit   found;
        logic [7:0] m, ra, rb;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gcd_start", 32'(gcd_start), 0);
        chk("rst_outputs", 32'({out_a, out_b, out_gcd, out_err, gcd_a, gcd_b}), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        tick();

        // 1: single job, exact issue latency, result one cycle after done, held under back-pressure
        out_ready = 1'b0;
        s0 = start_cnt;
        push_job(8'd5, 8'd20, 20);
        chk("t1_start_not_yet", 32'(gcd_start), 0);
        tick();
        chk("t1_start", 32'(gcd_start), 1);
        chk("t1_gcd_ops", 32'({gcd_a, gcd_b}), 32'({8'd5, 8'd20}));
        found = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gcd_done) begin
                found = 1;
                break;
            end
        end
        chk("t1_done_seen", 32'(found), 1);
        chk("t1_valid_after_done", 32'(out_valid), 1);
        chk("t1_out", 32'({out_a, out_b, out_gcd, out_err}), 32'({8'd5, 8'd20, 8'd5, 1'b0}));
        repeat (3) tick();
        out_ready = 1'b1;
        drain("t1", 50);
        chk("t1_start_count", 32'(start_cnt - s0), 1);

        // 2: back-to-back jobs complete in order
        push_job(8'd30, 8'd7, 20);
        push_job(8'd140, 8'd20, 20);
        push_job(8'd9, 8'd6, 20);
        drain("t2", 300);

        // 3: stalled engine fills the FIFO; the next job waits for a pop
        eng_delay = 40;
        base = got_total;
        push_job(8'd12, 8'd18, 20);
        push_job(8'd44, 8'd11, 20);
        push_job(8'd81, 8'd27, 20);
        push_job(8'd100, 8'd75, 20);
        push_job(8'd17, 8'd51, 20);
        chk("t3_full_in_ready", 32'(in_ready), 0);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_no_result_yet", 32'(got_total - base), 0);
        push_job(8'd64, 8'd48, 300);
        chk("t3_accept_after_pop", 32'(got_total - base >= 1), 1);
        drain("t3", 1000);
        eng_delay = 6;

        // 4: zero operands bypass the engine
        s0 = start_cnt;
        push_job(8'd0, 8'd12, 20);
        push_job(8'd0, 8'd0, 20);
        drain("t4", 100);
        chk("t4_no_start", 32'(start_cnt - s0), 0);

        // 5: hung engine times out, then the next job runs normally
        eng_hang = 1;
        push_job(8'd21, 8'd14, 20);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (gcd_start) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t5_start_seen", 32'(found), 1);
        cnt = 0;
        while (!out_valid && cnt < TIMEOUT + 100) begin
            tick();
            cnt++;
        end
        chk("t5_timeout_cycles", 32'(cnt), 32'(TIMEOUT + 2));
        drain("t5a", 50);
        eng_hang = 0;
        push_job(8'd21, 8'd14, 20);
        drain("t5b", 100);

        // 6: reset while waiting with jobs queued
        eng_hang = 1;
        push_job(8'd36, 8'd24, 20);
        push_job(8'd10, 8'd4, 20);
        push_job(8'd9, 8'd3, 20);
        repeat (5) tick();
        chk("t6_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 32'(gcd_start), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 0);
        chk("t6_rst_outputs", 32'({out_a, out_b, out_gcd, out_err}), 0);
        exp_q.delete();
        got_q.delete();
        base = got_total;
        repeat (3) @(posedge clk);
        #1;
        eng_hang = 0;
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t6_no_stale_result", 32'(got_total - base), 0);
        chk("t6_valid_after", 32'(out_valid), 0);
        chk("t6_busy_after", 32'(busy), 0);
        chk("t6_in_ready_after", 32'(in_ready), 1);

        // Randomized: random operands, engine delays and consumer back-pressure
        rand_ready = 1;
        rand_delay = 1;
        for (int j = 0; j < 24; j++) begin
            m  = 8'($urandom_range(1, 12));
            ra = 8'(m * $urandom_range(0, 20));
            rb = 8'(m * $urandom_range(0, 20));
            push_job(ra, rb, 300);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        drain("rand", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
